// File: rtl/pwm_timebase_ctrl_if.sv
// Register-bus interface for pwm_timebase_ctrl: one-cycle write strobe with
// a 2-bit address and WIDTH-bit write data.
interface pwm_timebase_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_wdata;

  modport master (output cfg_wr, output cfg_addr, output cfg_wdata);
  modport slave  (input  cfg_wr, input  cfg_addr, input  cfg_wdata);
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase controller: CTRL/AAR/CCR/RCR registers, IDLE/ARM/RUN/HALT sequencing,
// boundary detection and repetition-qualified update event. Optional PWM_PRELOAD_EN.
module pwm_timebase_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RCR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_timebase_ctrl_if.slave cfg,
  input  logic [WIDTH-1:0]  cnt_val,
  output logic              pwm_en,
  output logic              mode,
  output logic [WIDTH-1:0]  aar,
  output logic [WIDTH-1:0]  ccr,
  output logic              update_evt,
  output logic              running
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic             ctrl_mode_q, opm_q, mode_q, started_q, ue_q;
  logic [WIDTH-1:0] aar_q, ccr_q;
  logic [RCR_W-1:0] rcr_q, rep_q, rep_d;

  logic wr_ctrl, wr_aar, wr_ccr, wr_rcr;
  logic in_run, opm_ue, boundary, ug_run, ue_fire;

  assign wr_ctrl = cfg.cfg_wr && (cfg.cfg_addr == 2'd0);
  assign wr_aar  = cfg.cfg_wr && (cfg.cfg_addr == 2'd1);
  assign wr_ccr  = cfg.cfg_wr && (cfg.cfg_addr == 2'd2);
  assign wr_rcr  = cfg.cfg_wr && (cfg.cfg_addr == 2'd3);

  assign in_run = (state_q == StRun);
  // The cycle carrying a one-pulse UE must not detect a fresh boundary.
  assign opm_ue   = in_run && ue_q && opm_q;
  assign boundary = in_run && !opm_ue &&
                    ((cnt_val >= aar_q) || (mode_q && (cnt_val == '0) && started_q));
  assign ug_run   = in_run && wr_ctrl && cfg.cfg_wdata[3];
  assign ue_fire  = ug_run || (boundary && (rep_q == '0));

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    unique case (state_q)
      StIdle: if (wr_ctrl && cfg.cfg_wdata[0]) state_d = StArm;
      StArm: begin
        state_d = StRun;
        rep_d   = rcr_q;
      end
      StRun: begin
        if ((wr_ctrl && !cfg.cfg_wdata[0]) || opm_ue) state_d = StHalt;
        if (ue_fire)       rep_d = rcr_q;
        else if (boundary) rep_d = rep_q - RCR_W'(1);
      end
      StHalt: begin
        state_d = StIdle;
        rep_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rep_q       <= '0;
      ue_q        <= 1'b0;
      ctrl_mode_q <= 1'b0;
      opm_q       <= 1'b0;
      mode_q      <= 1'b0;
      rcr_q       <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      ue_q    <= ue_fire;
      if (wr_ctrl) begin
        ctrl_mode_q <= cfg.cfg_wdata[1];
        opm_q       <= cfg.cfg_wdata[2];
      end
      // Counting direction can only change while the counter is stopped.
      if (state_q == StIdle) mode_q <= wr_ctrl ? cfg.cfg_wdata[1] : ctrl_mode_q;
      if (wr_rcr) rcr_q <= cfg.cfg_wdata[RCR_W-1:0];
      if (state_q == StArm)              started_q <= 1'b0;
      else if (in_run && cnt_val != '0)  started_q <= 1'b1;
    end
  end

`ifdef PWM_PRELOAD_EN
  logic [WIDTH-1:0] aar_sh_q, ccr_sh_q;
  logic             transfer;

  assign transfer = (state_q == StArm) || ue_fire ||
                    (wr_ctrl && cfg.cfg_wdata[3] && !in_run);

  // Non-blocking update: a write coinciding with a transfer lands in the shadow only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aar_sh_q <= '1;
      ccr_sh_q <= '0;
      aar_q    <= '1;
      ccr_q    <= '0;
    end else begin
      if (wr_aar) aar_sh_q <= cfg.cfg_wdata;
      if (wr_ccr) ccr_sh_q <= cfg.cfg_wdata;
      if (transfer) begin
        aar_q <= aar_sh_q;
        ccr_q <= ccr_sh_q;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aar_q <= '1;
      ccr_q <= '0;
    end else begin
      if (wr_aar) aar_q <= cfg.cfg_wdata;
      if (wr_ccr) ccr_q <= cfg.cfg_wdata;
    end
  end
`endif

  assign pwm_en     = (state_q == StRun);
  assign running    = (state_q == StRun);
  assign mode       = mode_q;
  assign aar        = aar_q;
  assign ccr        = ccr_q;
  assign update_evt = ue_q;

endmodule
